// File: rtl/enc_snap_pkg.sv
// Shared constants and state encoding for the encoder snapshot scheduler.
package enc_snap_pkg;

    localparam int N_CH_DEF  = 4;
    localparam int CNT_W_DEF = 32;

    localparam logic [7:0] ADDR_STATUS = 8'h10;
    localparam logic [7:0] ADDR_TS     = 8'h11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        CAPTURE = 2'd2
    } snap_state_t;

endpackage

// File: rtl/enc_snapshot_sched_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
// The reset value is a parameter so idle-high signals such as chip selects start inactive.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/enc_snapshot_sched.sv
// Periodic coherent snapshot of encoder/odometer counters, frozen while SPI CS is low.
// Optional SNAP_TIMESTAMP_EN adds a capture timestamp readable at ADDR_TS.
module enc_snapshot_sched
    import enc_snap_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PERIOD = 50000,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH*CNT_W-1:0]   cnt_in,
    input  logic                    spi_cs,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [31:0]             rd_data,
    output logic                    snap_valid,
    output logic [15:0]             seq,
    output logic [1:0]              dbg_state
);

    localparam int TIMER_W = $clog2(PERIOD);

    snap_state_t          state_q;
    snap_state_t          state_d;
    logic [TIMER_W-1:0]   timer;
    logic                 tick;
    logic                 cs_s;
    logic                 lock;
    logic                 ovr_inc;
    logic                 capture;
    logic [7:0]           overrun_cnt;
    logic [15:0]          seq_r;
    logic                 snap_valid_r;
    logic [CNT_W-1:0]     bank [N_CH];

    sync2 #(.RST_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .d     (spi_cs),
        .q     (cs_s)
    );

    assign lock = ~cs_s;

    // Free-running period timer; lock never stalls it so the tick grid stays fixed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign tick = (timer == TIMER_W'(PERIOD - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ovr_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = lock ? PENDING : CAPTURE;
                end
            end
            PENDING: begin
                // Release wins over a coincident tick: one capture, no overrun.
                if (!lock) begin
                    state_d = CAPTURE;
                end else if (tick) begin
                    ovr_inc = 1'b1;
                end
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign capture   = (state_q == CAPTURE);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                bank[i] <= '0;
            end
            seq_r        <= '0;
            snap_valid_r <= 1'b0;
        end else if (capture) begin
            for (int i = 0; i < N_CH; i++) begin
                bank[i] <= cnt_in[i*CNT_W +: CNT_W];
            end
            seq_r        <= seq_r + 16'd1;
            snap_valid_r <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_cnt <= '0;
        end else if (ovr_inc && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

`ifdef SNAP_TIMESTAMP_EN
    logic [31:0] clk_cnt;
    logic [31:0] ts;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_cnt <= '0;
            ts      <= '0;
        end else begin
            clk_cnt <= clk_cnt + 32'd1;
            if (capture) begin
                ts <= clk_cnt;
            end
        end
    end
`endif

    always_comb begin
        rd_data = 32'h0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = 32'(bank[i]);
            end
        end
        if (rd_addr == ADDR_W'(ADDR_STATUS)) begin
            rd_data = {overrun_cnt, 7'b0, snap_valid_r, seq_r};
        end
`ifdef SNAP_TIMESTAMP_EN
        if (rd_addr == ADDR_W'(ADDR_TS)) begin
            rd_data = ts;
        end
`endif
    end

    assign seq        = seq_r;
    assign snap_valid = snap_valid_r;

endmodule

// File: tb/tb_enc_snapshot_sched.sv
// Directed bench for enc_snapshot_sched with PERIOD=10; cyc counts clk edges since reset release.
module tb_enc_snapshot_sched;

    localparam int PERIOD = 10;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    logic        clk;
    logic        reset;
    logic [127:0] cnt_in;
    logic        spi_cs;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        snap_valid;
    logic [15:0] seq;
    logic [1:0]  dbg_state;

    logic [31:0] cnt [4];
    int          cyc;
    int          checks;
    int          errors;
    rd_vec_t     vecs[$];
    logic [31:0] ts_exp;

    assign cnt_in = {cnt[3], cnt[2], cnt[1], cnt[0]};

    enc_snapshot_sched #(
        .N_CH   (4),
        .CNT_W  (32),
        .PERIOD (PERIOD),
        .ADDR_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cnt_in     (cnt_in),
        .spi_cs     (spi_cs),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .snap_valid (snap_valid),
        .seq        (seq),
        .dbg_state  (dbg_state)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %08h expected %08h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 40000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) chk("wait_cyc", cyc, n);
    endtask

    task automatic add_vec(input logic [7:0] a, input logic [31:0] e);
        rd_vec_t v;
        v.addr = a;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    // Applies and clears the queued read table; each read settles 1 time unit.
    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            rd_addr = vecs[i].addr;
            #1;
            chk($sformatf("%s addr %02h", tag, vecs[i].addr), rd_data, vecs[i].exp);
        end
        vecs.delete();
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] e);
        add_vec(a, e);
        run_vecs(tag);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        spi_cs  = 1'b1;
        rd_addr = 8'h0;
        cnt[0] = 32'd1; cnt[1] = 32'd2; cnt[2] = 32'd3; cnt[3] = 32'd4;
`ifdef SNAP_TIMESTAMP_EN
        ts_exp = 32'd10;
`else
        ts_exp = 32'd0;
`endif

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset state", {30'b0, dbg_state}, 32'd0);
        chk("reset snap_valid", {31'b0, snap_valid}, 32'd0);
        for (int a = 0; a < 4; a++) add_vec(8'(a), 32'h0);
        add_vec(8'h10, 32'h0);
        add_vec(8'h11, 32'h0);
        run_vecs("reset");
        reset = 1'b1;

        // 1: first capture ten clocks after release
        wait_cyc(10);
        chk("t1 state capture", {30'b0, dbg_state}, 32'd2);
        rd_chk("t1 latency", 8'h0, 32'h0);
        wait_cyc(11);
        add_vec(8'h00, 32'd1);
        add_vec(8'h01, 32'd2);
        add_vec(8'h02, 32'd3);
        add_vec(8'h03, 32'd4);
        add_vec(8'h10, 32'h0001_0001);
        add_vec(8'h20, 32'h0);
        run_vecs("t1");

        // 2: tick during CS low is deferred until release
        wait_cyc(21);
        rd_chk("t2 pre", 8'h10, 32'h0001_0002);
        wait_cyc(23);
        spi_cs = 1'b0;
        wait_cyc(26);
        cnt[0] = 32'd99;
        wait_cyc(30);
        chk("t2 pending", {30'b0, dbg_state}, 32'd1);
        rd_chk("t2 frozen", 8'h00, 32'd1);
        wait_cyc(33);
        spi_cs = 1'b1;
        wait_cyc(36);
        chk("t2 capture", {30'b0, dbg_state}, 32'd2);
        rd_chk("t2 still old", 8'h00, 32'd1);
        wait_cyc(37);
        add_vec(8'h00, 32'd99);
        add_vec(8'h10, 32'h0001_0003);
        run_vecs("t2");

        // 3: 25-clk CS low spanning three ticks -> two overruns, one capture
        wait_cyc(44);
        spi_cs = 1'b0;
        wait_cyc(45);
        cnt[1] = 32'd55;
        wait_cyc(69);
        spi_cs = 1'b1;
        wait_cyc(72);
        chk("t3 capture", {30'b0, dbg_state}, 32'd2);
        rd_chk("t3 pre", 8'h10, 32'h0201_0004);
        wait_cyc(73);
        add_vec(8'h01, 32'd55);
        add_vec(8'h10, 32'h0201_0005);
        run_vecs("t3");

        // 4: release lands exactly in the tick cycle while pending
        wait_cyc(82);
        spi_cs = 1'b0;
        wait_cyc(95);
        chk("t4 pending", {30'b0, dbg_state}, 32'd1);
        wait_cyc(97);
        spi_cs = 1'b1;
        wait_cyc(100);
        chk("t4 capture", {30'b0, dbg_state}, 32'd2);
        wait_cyc(101);
        rd_chk("t4", 8'h10, 32'h0201_0007);
        wait_cyc(103);
        chk("t4 single", {30'b0, dbg_state}, 32'd0);

        // 5: seq wrap, then overrun saturation
        wait_cyc(112);
        force dut.seq_r = 16'hFFFF;
        wait_cyc(113);
        release dut.seq_r;
        rd_chk("t5 forced", 8'h10, 32'h0201_FFFF);
        wait_cyc(121);
        rd_chk("t5 wrap", 8'h10, 32'h0201_0000);
        chk("t5 seq port", {16'b0, seq}, 32'h0);
        chk("t5 snap_valid", {31'b0, snap_valid}, 32'd1);
        wait_cyc(122);
        spi_cs = 1'b0;
        wait_cyc(30120);
        rd_chk("t5 saturate", 8'h10, 32'hFF01_0000);
        wait_cyc(30122);
        spi_cs = 1'b1;
        wait_cyc(30127);
        rd_chk("t5 after", 8'h10, 32'hFF01_0001);

        // 6: reset while pending discards everything
        wait_cyc(30131);
        spi_cs = 1'b0;
        wait_cyc(30142);
        chk("t6 pending", {30'b0, dbg_state}, 32'd1);
        reset  = 1'b0;
        spi_cs = 1'b1;
        #1;
        chk("t6 state idle", {30'b0, dbg_state}, 32'd0);
        chk("t6 seq", {16'b0, seq}, 32'h0);
        for (int a = 0; a < 4; a++) add_vec(8'(a), 32'h0);
        add_vec(8'h10, 32'h0);
        add_vec(8'h11, 32'h0);
        run_vecs("t6 reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_cyc(11);
        add_vec(8'h00, 32'd99);
        add_vec(8'h01, 32'd55);
        add_vec(8'h02, 32'd3);
        add_vec(8'h03, 32'd4);
        add_vec(8'h10, 32'h0001_0001);
        add_vec(8'h11, ts_exp);
        run_vecs("t6 post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
